// File: rtl/ili9341_panel_rx.sv
// rtl/ili9341_panel_rx.sv - ILI9341 8080 write-bus panel responder with RGB565 pixel capture
// Optional MADCTL mirroring is compiled in with ILI9341_PANEL_MADCTL_EN.
module ili9341_panel_rx #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lcd_nreset,
  input  logic        lcd_cmd_data,
  input  logic        lcd_wr,
  input  logic [7:0]  lcd_d,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        disp_on,
  output logic        sleep_n
);

  localparam logic [15:0] L_EC_RST = 16'(WIDTH - 1);
  localparam logic [15:0] L_EP_RST = 16'(HEIGHT - 1);
  localparam logic [15:0] L_WIDTH  = 16'(WIDTH);
  localparam logic [15:0] L_HEIGHT = 16'(HEIGHT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET,
    ST_PASET,
    ST_RAMWR,
    ST_SKIP,
    ST_MADCTL
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_wr_q;
  logic        w_strobe;
  logic        w_cmd_strobe;
  logic        w_data_strobe;
  logic        w_clear;
  logic        w_in_bounds;
  logic [15:0] r_sc;
  logic [15:0] r_ec;
  logic [15:0] r_sp;
  logic [15:0] r_ep;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic [1:0]  r_pcnt;
  logic        r_phase;
  logic [7:0]  r_hi;
  logic [23:0] r_pbuf;
  logic [8:0]  w_px;
  logic [8:0]  w_py;

  assign w_strobe      = lcd_wr & ~r_wr_q;
  assign w_cmd_strobe  = w_strobe & lcd_nreset & ~lcd_cmd_data;
  assign w_data_strobe = w_strobe & lcd_nreset & lcd_cmd_data;
  // SWRESET shares the hardware-reset clear path.
  assign w_clear       = ~lcd_nreset | (w_cmd_strobe & (lcd_d == 8'h01));
  assign w_in_bounds   = (r_x < L_WIDTH) && (r_y < L_HEIGHT);

`ifdef ILI9341_PANEL_MADCTL_EN
  localparam logic [8:0] L_XMAX = 9'(WIDTH - 1);
  localparam logic [8:0] L_YMAX = 9'(HEIGHT - 1);
  logic [7:0] r_madctl;

  assign w_px = r_madctl[6] ? (L_XMAX - r_x[8:0]) : r_x[8:0];
  assign w_py = r_madctl[7] ? (L_YMAX - r_y[8:0]) : r_y[8:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_madctl <= 8'h00;
    end else if (w_clear) begin
      r_madctl <= 8'h00;
    end else if (w_data_strobe && (r_state == ST_MADCTL)) begin
      r_madctl <= lcd_d;
    end
  end
`else
  assign w_px = r_x[8:0];
  assign w_py = r_y[8:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_clear) begin
      w_state_next = ST_IDLE;
    end else if (w_cmd_strobe) begin
      case (lcd_d)
        8'h10, 8'h11, 8'h28, 8'h29: w_state_next = ST_IDLE;
        8'h2A:                      w_state_next = ST_CASET;
        8'h2B:                      w_state_next = ST_PASET;
        8'h2C:                      w_state_next = ST_RAMWR;
`ifdef ILI9341_PANEL_MADCTL_EN
        8'h36:                      w_state_next = ST_MADCTL;
`endif
        default:                    w_state_next = ST_SKIP;
      endcase
    end else if (w_data_strobe) begin
      case (r_state)
        ST_CASET, ST_PASET: if (r_pcnt == 2'd3) w_state_next = ST_SKIP;
        ST_MADCTL:          w_state_next = ST_SKIP;
        default:            w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_q    <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_code  <= 8'h00;
    end else begin
      r_wr_q    <= lcd_wr;
      cmd_valid <= w_cmd_strobe;
      if (!lcd_nreset) begin
        cmd_code <= 8'h00;
      end else if (w_cmd_strobe) begin
        cmd_code <= lcd_d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_x     <= 9'd0;
      pix_y     <= 9'd0;
      pix_data  <= 16'h0000;
      disp_on   <= 1'b0;
      sleep_n   <= 1'b0;
      r_sc      <= 16'h0000;
      r_ec      <= L_EC_RST;
      r_sp      <= 16'h0000;
      r_ep      <= L_EP_RST;
      r_x       <= 16'h0000;
      r_y       <= 16'h0000;
      r_pcnt    <= 2'd0;
      r_phase   <= 1'b0;
      r_hi      <= 8'h00;
      r_pbuf    <= 24'h000000;
    end else begin
      pix_valid <= 1'b0;
      if (w_clear) begin
        pix_x    <= 9'd0;
        pix_y    <= 9'd0;
        pix_data <= 16'h0000;
        disp_on  <= 1'b0;
        sleep_n  <= 1'b0;
        r_sc     <= 16'h0000;
        r_ec     <= L_EC_RST;
        r_sp     <= 16'h0000;
        r_ep     <= L_EP_RST;
        r_x      <= 16'h0000;
        r_y      <= 16'h0000;
        r_pcnt   <= 2'd0;
        r_phase  <= 1'b0;
        r_hi     <= 8'h00;
        r_pbuf   <= 24'h000000;
      end else if (w_cmd_strobe) begin
        r_pcnt  <= 2'd0;
        r_phase <= 1'b0;
        case (lcd_d)
          8'h10: sleep_n <= 1'b0;
          8'h11: sleep_n <= 1'b1;
          8'h28: disp_on <= 1'b0;
          8'h29: disp_on <= 1'b1;
          8'h2C: begin
            r_x <= r_sc;
            r_y <= r_sp;
          end
          default: ;
        endcase
      end else if (w_data_strobe) begin
        case (r_state)
          ST_CASET, ST_PASET: begin
            r_pcnt <= r_pcnt + 2'd1;
            r_pbuf <= {r_pbuf[15:0], lcd_d};
            // Window only commits once all four parameter bytes are in.
            if (r_pcnt == 2'd3) begin
              if (r_state == ST_CASET) begin
                r_sc <= r_pbuf[23:8];
                r_ec <= {r_pbuf[7:0], lcd_d};
              end else begin
                r_sp <= r_pbuf[23:8];
                r_ep <= {r_pbuf[7:0], lcd_d};
              end
            end
          end
          ST_RAMWR: begin
            if (!r_phase) begin
              r_hi    <= lcd_d;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              if (w_in_bounds) begin
                pix_valid <= 1'b1;
                pix_data  <= {r_hi, lcd_d};
                pix_x     <= w_px;
                pix_y     <= w_py;
              end
              // Off-panel pixels still consume a window position.
              if (r_x >= r_ec) begin
                r_x <= r_sc;
                r_y <= (r_y >= r_ep) ? r_sp : (r_y + 16'd1);
              end else begin
                r_x <= r_x + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
